alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
Round-robin arbiter and sequencer that shares one combinational 32-bit ALU among NREQ requesters, such as a multi-cycle datapath's PC-increment, address-generation and execute paths. It accepts one operation at a time over a valid/ready handshake and drives the registered operands and control onto the ALU. It captures result and zero flag, then returns them with the requester index over a second valid/ready handshake.

Parameters:
WIDTH, 32, operand/result width
NREQ, 2, number of requesters (2..8)
IDW, 3, width of requester index (must be >= clog2(NREQ))

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operation valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_a  in  NREQ*WIDTH  operand a, requester i in slice [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  operand b, packed likewise
req_ctrl  in  NREQ*3  ALU control, packed 3 bits per requester
alu_a  out  WIDTH  registered operand a to ALU
alu_b  out  WIDTH  registered operand b to ALU
alu_control  out  3  registered control to ALU
alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_control)
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  index of requester owning the response
rsp_result  out  WIDTH  captured result
rsp_zero  out  1  captured zero flag
rsp_err  out  1  illegal control code flag
busy  out  1  high in EXEC or RESP

Behaviour:
- Legal control codes: 000 add, 001 sub, 010 and, 011 or, 101 slt. Codes 100, 110 and 111 are illegal.
- FSM states: IDLE, EXEC, RESP.
- Reset (async, reset_n=0) forces:
  - state=IDLE, last_grant=NREQ-1;
  - alu_a=0, alu_b=0, alu_control=000;
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0.
- Reset mid-operation: the in-flight operation is dropped and no response is produced. Requesters must re-present.
- Grant selection:
  - Round-robin search starts at (last_grant+1) mod NREQ and picks the first i with req_valid[i]=1.
  - req_ready is combinational, one-hot at the granted index. It is asserted only in IDLE, or in RESP when rsp_ready=1.
  - req_ready is never asserted for an index whose req_valid=0.
- Accept (transfer = req_valid[g] & req_ready[g]) at edge N:
  - alu_a, alu_b and alu_control load slice g; grant index is stored; last_grant<=g; state<=EXEC.
  - Illegal control codes are still issued to the ALU; err_pending<=1.
- EXEC (one cycle): on the edge, rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_err<=err_pending, rsp_id<=stored grant, rsp_valid<=1, state<=RESP.
  - If err_pending: rsp_result<=0 and rsp_zero<=0.
- RESP:
  - rsp_valid=1. rsp_id, rsp_result, rsp_zero and rsp_err hold stable until rsp_ready=1.
  - On rsp_ready=1 with no pending request: rsp_valid<=0, state<=IDLE.
  - On rsp_ready=1 with a pending request: response completes and a new request is accepted in the same cycle, state<=EXEC. rsp_valid stays 1 only from the next response onward, so it drops for exactly the EXEC cycle.
- Latency: accept at edge N gives rsp_valid=1 after edge N+1 (response visible in cycle N+2). Peak throughput is one operation per 2 cycles.
- alu_a, alu_b and alu_control hold their last values outside EXEC; there is no toggling when idle.
- req_valid deasserting without a handshake is legal and ignored. Requester payload is sampled only at the accept edge.
- Simultaneous valid from all requesters: each is served once per NREQ grants (strict rotation). There is no starvation while rsp_ready eventually asserts.
- busy = (state != IDLE).

Test Plan:
- Reset release, req0 a=5 b=7 ctrl=000, rsp_ready=1 -> req_ready[0] same cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_result=12, rsp_zero=0, rsp_err=0.
- req0 and req1 valid every cycle, a=i+1, b=i+1, ctrl=001 -> grants alternate 0,1,0,1; every response result=0, zero=1; back-to-back rsp_valid pattern 1,0,1,0.
- req1 a=0xFFFFFFFE (-2) b=3 ctrl=101, rsp_ready held 0 for 5 cycles -> rsp_valid=1 and rsp_result=1 stable for all 5 cycles; no new req_ready during the hold; completes when rsp_ready=1.
- req0 ctrl=110 a=1 b=1 -> rsp_err=1, rsp_result=0, rsp_zero=0; the next legal op (and, 0xF0F0 & 0x0FF0) gives 0x00F0 with rsp_err=0.
- Accept req0, then assert reset_n=0 during EXEC -> all outputs 0 immediately. After release, no stale rsp_valid; the first grant goes to req0 when both are valid.
- NREQ=4, all valid, rsp_ready=1 for 8 ops -> rsp_id sequence 0,1,2,3,0,1,2,3.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU
// among NREQ requesters, with valid/ready request and response sides.
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int IDW   = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ*3-1:0]       req_ctrl,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output logic [2:0]              alu_control,
    input  logic [WIDTH-1:0]        alu_result,
    input  logic                    alu_zero,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_result,
    output logic                    rsp_zero,
    output logic                    rsp_err,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_last_grant;
    logic [IDW-1:0]   r_gidx;
    logic             r_err_pend;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_ctrl;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp_err;

    logic             w_found;
    logic [IDW-1:0]   w_gidx;
    logic             w_can;
    logic             w_take;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [2:0]       w_sel_ctrl;
    logic             w_legal;

    // Rotating priority: indices above last grant first, then wrap to 0.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && i > int'(r_last_grant)) begin
                w_found = 1'b1;
                w_gidx  = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && i <= int'(r_last_grant)) begin
                w_found = 1'b1;
                w_gidx  = IDW'(i);
            end
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_ctrl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gidx == IDW'(i)) begin
                w_sel_a    = req_a[i*WIDTH +: WIDTH];
                w_sel_b    = req_b[i*WIDTH +: WIDTH];
                w_sel_ctrl = req_ctrl[i*3 +: 3];
            end
        end
    end

    assign w_can   = (r_state == S_IDLE) ||
                     ((r_state == S_RESP) && rsp_ready);
    assign w_take  = w_can && w_found;
    assign w_legal = w_sel_ctrl inside {3'b000, 3'b001, 3'b010,
                                        3'b011, 3'b101};

    // One-hot ready at the granted index, only when a slot is free.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_take && (w_gidx == IDW'(i));
        end
    end

    // Capture the accepted operation and drive it onto the ALU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= 3'b000;
            r_gidx       <= '0;
            r_last_grant <= IDW'(NREQ - 1);
            r_err_pend   <= 1'b0;
        end else if (w_take) begin
            r_alu_a      <= w_sel_a;
            r_alu_b      <= w_sel_b;
            r_alu_ctrl   <= w_sel_ctrl;
            r_gidx       <= w_gidx;
            r_last_grant <= w_gidx;
            r_err_pend   <= !w_legal;
        end
    end

    // Sequencer: IDLE -> EXEC -> RESP, with overlap of accept and response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_result <= r_err_pend ? '0 : alu_result;
                    r_rsp_zero   <= r_err_pend ? 1'b0 : alu_zero;
                    r_rsp_err    <= r_err_pend;
                    r_rsp_id     <= r_gidx;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_take ? S_EXEC : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_ctrl;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_err     = r_rsp_err;
    assign busy        = (r_state != S_IDLE);

endmodule
